// File: rtl/eval_lane_scheduler_if.sv
// Request/response bundle between NREQ requesters, the shared evaluation lane
// and the result consumer.
interface eval_lane_scheduler_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0][7:0] req_a;
  logic [NREQ-1:0][1:0] req_b;
  logic [NREQ-1:0][1:0] req_c;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_d;
  logic                 rsp_e;

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_d, rsp_e
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_d, rsp_e
  );
endinterface

// File: rtl/eval_lane_scheduler.sv
// Round-robin scheduler time-multiplexing one registered (d, e) evaluation
// lane among NREQ requesters, with tagged valid/ready responses.
//
// state | meaning
// IDLE  | searching req_valid from ptr for the next grant
// EVAL  | operands captured, registering d/e into the response
// RESP  | response presented, waiting for rsp_ready
module eval_lane_scheduler #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  eval_lane_scheduler_if.slave  bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      done_count
);
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [1:0]       a_q, a_d;
  logic [1:0]       b_q, b_d;
  logic [1:0]       c_q, c_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_d_q, rsp_d_d;
  logic             rsp_e_q, rsp_e_d;
  logic [CNT_W-1:0] done_count_q, done_count_d;
  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  logic             unused_a_hi;

  function automatic logic [ID_W-1:0] wrap_idx(input int v);
    return ID_W'(v % NREQ);
  endfunction

  // Only a[1:0] takes part in the function.
  assign unused_a_hi = ^bus.req_a;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && bus.req_valid[wrap_idx(int'(ptr_q) + i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(int'(ptr_q) + i);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (reset_n && state_q == IDLE && gnt_found) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_d_d      = rsp_d_q;
    rsp_e_d      = rsp_e_q;
    done_count_d = done_count_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          a_d     = bus.req_a[gnt_idx][1:0];
          b_d     = bus.req_b[gnt_idx];
          c_d     = bus.req_c[gnt_idx];
          id_d    = gnt_idx;
          ptr_d   = wrap_idx(int'(gnt_idx) + 1);
          state_d = EVAL;
        end
      end
      EVAL: begin
        rsp_d_d     = ((a_q[0] | b_q[0]) & (a_q[1] | b_q[1])) | c_q[1];
        rsp_e_d     = ((a_q[1] | b_q[0]) & (a_q[0] | b_q[1])) | c_q[0];
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d  = 1'b0;
          done_count_d = done_count_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_d_q      <= 1'b0;
      rsp_e_q      <= 1'b0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_d_q      <= rsp_d_d;
      rsp_e_q      <= rsp_e_d;
      done_count_q <= done_count_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_d     = rsp_d_q;
  assign bus.rsp_e     = rsp_e_q;
  assign busy          = (state_q != IDLE);
  assign done_count    = done_count_q;
endmodule

// File: tb/tb_eval_lane_scheduler.sv
// Randomized and directed bench for eval_lane_scheduler with a queue-based
// scoreboard fed by a round-robin reference model.
module tb_eval_lane_scheduler;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            d;
    logic            e;
  } rsp_t;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] done_count;

  eval_lane_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  eval_lane_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  rsp_t            sb_q[$];
  int              grant_log[$];
  int              m_ptr   = 0;
  int              m_phase = 0;
  int              m_done  = 0;
  rsp_t            m_last  = '0;
  logic [NREQ-1:0] acc_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t ref_eval(input int g, input logic [7:0] a,
                                    input logic [1:0] b, input logic [1:0] c);
    rsp_t r;
    r.id = ID_W'(g);
    r.d  = ((a[0] | b[0]) & (a[1] | b[1])) | c[1];
    r.e  = ((a[1] | b[0]) & (a[0] | b[1])) | c[0];
    return r;
  endfunction

  // Model phase: 0 lane free, 1 grant taken last cycle, 2 response owed.
  always @(negedge clock) begin
    logic [NREQ-1:0] exp_rdy;
    int              g;
    exp_rdy  = '0;
    g        = -1;
    acc_mask = bus.req_valid & bus.req_ready;
    if (!reset_n) begin
      check("req_ready_in_reset", 32'(bus.req_ready), 32'd0);
      sb_q.delete();
      m_ptr   = 0;
      m_phase = 0;
      m_done  = 0;
      m_last  = '0;
    end else begin
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("done_count", 32'(done_count), 32'(m_done % (1 << CNT_W)));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_phase == 2));
      case (m_phase)
        0: begin
          for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
          end
          if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            sb_q.push_back(ref_eval(g, bus.req_a[g], bus.req_b[g], bus.req_c[g]));
            grant_log.push_back(g);
            m_ptr   = (g + 1) % NREQ;
            m_phase = 1;
          end
          check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
          check("retained_rsp", 32'({bus.rsp_id, bus.rsp_d, bus.rsp_e}), 32'(m_last));
        end
        1: begin
          check("req_ready_eval", 32'(bus.req_ready), 32'd0);
          m_phase = 2;
        end
        default: begin
          check("req_ready_resp", 32'(bus.req_ready), 32'd0);
          if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty: got response, expected none at %0t", $time);
          end else begin
            check("rsp_payload", 32'({bus.rsp_id, bus.rsp_d, bus.rsp_e}), 32'(sb_q[0]));
            if (bus.rsp_ready) begin
              m_last  = sb_q.pop_front();
              m_done++;
              m_phase = 0;
            end
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic raise(input int i);
    bus.req_valid[i] = 1'b1;
    bus.req_a[i]     = 8'($urandom);
    bus.req_b[i]     = 2'($urandom);
    bus.req_c[i]     = 2'($urandom);
  endtask

  task automatic wait_clear(input logic [NREQ-1:0] mask);
    int n;
    for (n = 0; n < 60; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (acc_mask[i]) bus.req_valid[i] = 1'b0;
      if ((bus.req_valid & mask) == '0) break;
    end
    if (n == 60) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout: pending %0h, expected none", bus.req_valid & mask);
      bus.req_valid = bus.req_valid & ~mask;
    end
  endtask

  task automatic do_req(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) if (mask[i] && !bus.req_valid[i]) raise(i);
    wait_clear(mask);
  endtask

  task automatic check_log(input string name, input int exp[$]);
    check({name, "_len"}, 32'(grant_log.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < grant_log.size(); k++)
      check(name, 32'(grant_log[k]), 32'(exp[k]));
  endtask

  logic [7:0] dir_a[3] = '{8'h01, 8'h02, 8'hFC};
  logic [1:0] dir_b[3] = '{2'b10, 2'b00, 2'b00};
  logic [1:0] dir_c[3] = '{2'b00, 2'b01, 2'b10};
  logic       dir_d[3] = '{1'b1, 1'b0, 1'b1};
  logic       dir_e[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;

    // Function table on requester 0; response must be up at T+2.
    for (int t = 0; t < 3; t++) begin
      bus.req_a[0] = dir_a[t];
      bus.req_b[0] = dir_b[t];
      bus.req_c[0] = dir_c[t];
      bus.req_valid[0] = 1'b1;
      wait_clear(4'b0001);
      step();
      @(negedge clock);
      check("fn_valid", 32'(bus.rsp_valid), 32'd1);
      check("fn_d", 32'(bus.rsp_d), 32'(dir_d[t]));
      check("fn_e", 32'(bus.rsp_e), 32'(dir_e[t]));
      check("fn_id", 32'(bus.rsp_id), 32'd0);
      repeat (2) step();
    end

    // All four held valid from reset.
    reset_n = 1'b0;
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) raise(i);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (17) begin
      step();
      for (int i = 0; i < NREQ; i++) if (acc_mask[i]) raise(i);
    end
    bus.req_valid = '0;
    repeat (4) step();
    if (grant_log.size() > 6) grant_log = grant_log[0:5];
    check_log("rr_order", '{0, 1, 2, 3, 0, 1});

    // Sparse fairness.
    grant_log.delete();
    do_req(4'b0001);
    do_req(4'b0101);
    do_req(4'b1000);
    repeat (3) step();
    do_req(4'b0010);
    repeat (4) step();
    check_log("sparse_order", '{0, 2, 0, 3, 1});

    // Backpressure: five RESP cycles with rsp_ready low.
    bus.rsp_ready = 1'b0;
    do_req(4'b0100);
    raise(0);
    repeat (6) step();
    bus.rsp_ready = 1'b1;
    wait_clear(4'b0001);
    repeat (4) step();

    // Reset during EVAL with requester 2 still requesting.
    grant_log.delete();
    do_req(4'b0100);
    raise(2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_done", 32'(done_count), 32'd0);
    wait_clear(4'b0100);
    repeat (4) step();
    check_log("rst_order", '{2, 2});

    // Random traffic with random backpressure.
    repeat (2000) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) bus.req_valid[i] = 1'b0;
        if (bus.req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          raise(i);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (10) step();
    check("drain_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
